// File: rtl/fmad.sv
// Multi-cycle fused multiply-add/subtract: shift-add multiply (one partial product per
// clock) then one add/subtract clock. Define FMAD_SIGNED_EN for two's-complement operands.
module fmad #(
   parameter int WIDTH    = 8,
   parameter int OUTWIDTH = 2 * WIDTH
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic [WIDTH-1:0]    fmadMulIn1,
   input  logic [WIDTH-1:0]    fmadMulIn2,
   input  logic [WIDTH-1:0]    fmadAddIn,
   input  logic                sub,
   output logic [OUTWIDTH-1:0] fmadOut,
   output logic                fmadDone
);

   localparam int CNTW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} fmadState_t;

   fmadState_t state, nextState;

   logic [OUTWIDTH-1:0] mcand;
   logic [WIDTH-1:0]    mplier;
   logic [OUTWIDTH-1:0] addend;
   logic [OUTWIDTH-1:0] acc;
   logic [CNTW-1:0]     count;
   logic                subReg;
   logic                negReg;
   logic                load;

   // Magnitude fed to the multiplier; identity for unsigned operands.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
`ifdef FMAD_SIGNED_EN
      return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
`else
      return v;
`endif
   endfunction

   function automatic logic [OUTWIDTH-1:0] extendAddend(input logic [WIDTH-1:0] v);
`ifdef FMAD_SIGNED_EN
      return {{(OUTWIDTH-WIDTH){v[WIDTH-1]}}, v};
`else
      return {{(OUTWIDTH-WIDTH){1'b0}}, v};
`endif
   endfunction

   function automatic logic productNegative(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
`ifdef FMAD_SIGNED_EN
      return a[WIDTH-1] ^ b[WIDTH-1];
`else
      return 1'b0;
`endif
   endfunction

   // Final combine wraps modulo 2^OUTWIDTH; there is deliberately no carry/borrow out.
   function automatic logic [OUTWIDTH-1:0] combine(input logic [OUTWIDTH-1:0] prodMag,
                                                   input logic                neg,
                                                   input logic [OUTWIDTH-1:0] addV,
                                                   input logic                doSub);
      logic [OUTWIDTH-1:0] prod;
      prod = neg ? (~prodMag + OUTWIDTH'(1)) : prodMag;
      return doSub ? (prod - addV) : (prod + addV);
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      load      = 1'b0;
      case (state)
         IDLE: if (start) begin
            nextState = MUL;
            load      = 1'b1;
         end
         MUL:  if (count == LAST) nextState = ADD;
         ADD:  nextState = DONE;
         DONE: if (start) begin
            nextState = MUL;
            load      = 1'b1;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mcand    <= '0;
         mplier   <= '0;
         addend   <= '0;
         acc      <= '0;
         count    <= '0;
         subReg   <= 1'b0;
         negReg   <= 1'b0;
         fmadOut  <= '0;
         fmadDone <= 1'b0;
      end else if (load) begin
         mcand    <= {{(OUTWIDTH-WIDTH){1'b0}}, magnitude(fmadMulIn1)};
         mplier   <= magnitude(fmadMulIn2);
         addend   <= extendAddend(fmadAddIn);
         subReg   <= sub;
         negReg   <= productNegative(fmadMulIn1, fmadMulIn2);
         acc      <= '0;
         count    <= '0;
         fmadDone <= 1'b0;
      end else if (state == MUL) begin
         // Shifting both operands each clock is equivalent to testing bit[count]
         // and adding (multiplicand << count).
         if (mplier[0]) acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + CNTW'(1);
      end else if (state == ADD) begin
         fmadOut  <= combine(acc, negReg, addend, subReg);
         fmadDone <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fmad.sv
// Randomized and directed bench for fmad, checked against an arithmetic reference model.
module tb_fmad;

   localparam int W  = 8;
   localparam int OW = 2 * W;

   logic          clock;
   logic          reset;
   logic          start;
   logic [W-1:0]  fmadMulIn1;
   logic [W-1:0]  fmadMulIn2;
   logic [W-1:0]  fmadAddIn;
   logic          sub;
   logic [OW-1:0] fmadOut;
   logic          fmadDone;

   int            vectors;
   int            miscompares;
   logic [OW-1:0] lastOut;

   fmad #(.WIDTH(W)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .fmadMulIn1 (fmadMulIn1),
      .fmadMulIn2 (fmadMulIn2),
      .fmadAddIn  (fmadAddIn),
      .sub        (sub),
      .fmadOut    (fmadOut),
      .fmadDone   (fmadDone)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [OW-1:0] observed,
                      input logic [OW-1:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  tag, observed, observed, expected, expected, $time);
      end
   endtask

   // Reference: plain integer arithmetic, truncated to the result width.
   function automatic logic [OW-1:0] refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [W-1:0] c, input logic s);
      longint pa, pb, pc, r;
`ifdef FMAD_SIGNED_EN
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      pc = longint'($signed(c));
`else
      pa = longint'(a);
      pb = longint'(b);
      pc = longint'(c);
`endif
      r = s ? (pa * pb - pc) : (pa * pb + pc);
      return r[OW-1:0];
   endfunction

   task automatic randomInputs();
      fmadMulIn1 = W'($urandom);
      fmadMulIn2 = W'($urandom);
      fmadAddIn  = W'($urandom);
      sub        = 1'($urandom);
   endtask

   // Runs one operation; pulseAt>0 asserts a spurious start before that MUL/ADD edge.
   task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic s,
                        input int pulseAt, input string tag);
      logic [OW-1:0] exp;
      exp        = refModel(a, b, c, s);
      fmadMulIn1 = a;
      fmadMulIn2 = b;
      fmadAddIn  = c;
      sub        = s;
      start      = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      randomInputs();
      chk({tag, ".doneLow"}, OW'(fmadDone), OW'(0));
      chk({tag, ".holdOut"}, fmadOut, lastOut);
      for (int i = 1; i <= W + 1; i++) begin
         if (i == pulseAt) begin
            start = 1'b1;
            randomInputs();
         end
         @(posedge clock); #1;
         start = 1'b0;
         if (i == W) begin
            chk({tag, ".notYetDone"}, OW'(fmadDone), OW'(0));
            chk({tag, ".prevOut"}, fmadOut, lastOut);
         end
      end
      chk({tag, ".done"}, OW'(fmadDone), OW'(1));
      chk({tag, ".out"}, fmadOut, exp);
      lastOut = exp;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      lastOut     = '0;
      reset       = 1'b1;
      start       = 1'b0;
      fmadMulIn1  = '0;
      fmadMulIn2  = '0;
      fmadAddIn   = '0;
      sub         = 1'b0;
      #1;
      chk("reset.out", fmadOut, OW'(0));
      chk("reset.done", OW'(fmadDone), OW'(0));
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;
      chk("idle.done", OW'(fmadDone), OW'(0));

      runOp(8'd200, 8'd100, 8'd50, 1'b0, 0, "mulAdd");
      runOp(8'd3, 8'd4, 8'd20, 1'b1, 0, "subWrap");
      runOp(8'd255, 8'd255, 8'd255, 1'b0, 0, "maxAdd");
      runOp(8'd0, 8'd77, 8'd1, 1'b1, 0, "zeroSub");

      // Asynchronous reset in the middle of a multiply.
      fmadMulIn1 = 8'd7;
      fmadMulIn2 = 8'd9;
      fmadAddIn  = 8'd1;
      sub        = 1'b0;
      start      = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (3) @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      chk("midReset.done", OW'(fmadDone), OW'(0));
      chk("midReset.out", fmadOut, OW'(0));
      @(posedge clock); #1;
      reset   = 1'b0;
      lastOut = '0;
      @(posedge clock); #1;
      chk("midReset.idle", OW'(fmadDone), OW'(0));
      runOp(8'd7, 8'd9, 8'd1, 1'b0, 0, "afterReset");

      // Back-to-back from DONE with inputs scrambled after the start edge.
      runOp(8'd10, 8'd10, 8'd100, 1'b1, 0, "backToBack");

      // Hold in DONE.
      for (int i = 0; i < 20; i++) begin
         @(posedge clock); #1;
         chk("hold.done", OW'(fmadDone), OW'(1));
         chk("hold.out", fmadOut, lastOut);
      end

      // Spurious start pulses during MUL and ADD are ignored.
      runOp(8'd123, 8'd45, 8'd67, 1'b0, 3, "ignoreMul");
      runOp(8'd17, 8'd201, 8'd250, 1'b1, W, "ignoreMul2");
      runOp(8'd99, 8'd98, 8'd7, 1'b0, W + 1, "ignoreAdd");

      for (int n = 0; n < 40; n++) begin
         logic [W-1:0] a, b, c;
         logic s;
         a = W'($urandom);
         b = W'($urandom);
         c = W'($urandom);
         s = 1'($urandom);
         if (n % 8 == 0) a = {1'b1, {(W-1){1'b0}}};
         runOp(a, b, c, s, (n % 5 == 0) ? int'($urandom_range(1, W)) : 0, "rand");
         if (n % 4 == 0) repeat ($urandom_range(0, 3)) @(posedge clock);
         #0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fmad.md
Name: fmad

Overview:
- Multi-cycle fused multiply-add/subtract unit for unsigned integers.
- Computes fmadMulIn1 * fmadMulIn2 ± fmadAddIn into a double-width result.
- Uses a sequential shift-add multiplier (one partial product per cycle), followed by a single add/subtract cycle.
- Integer datapath building block of the FPU; controlled by a start/done handshake.

Parameters:
- WIDTH, 8, operand width in bits (≥2).
- OUTWIDTH, 2*WIDTH, result width (derived; not overridden independently).

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin an operation; sampled on rising clock edge.
- fmadMulIn1  input  WIDTH  multiplicand (unsigned).
- fmadMulIn2  input  WIDTH  multiplier (unsigned).
- fmadAddIn  input  WIDTH  addend/subtrahend (unsigned, zero-extended to OUTWIDTH).
- sub  input  1  0 = add fmadAddIn, 1 = subtract fmadAddIn.
- fmadOut  output  OUTWIDTH  result.
- fmadDone  output  1  result valid.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE; fmadOut=0; fmadDone=0.
  - Internal accumulator, counter and latched operands cleared; in-flight operation discarded.
- States: IDLE, MUL, ADD, DONE.
- IDLE: on edge with start=1:
  - Latch fmadMulIn1, fmadMulIn2, fmadAddIn, sub.
  - Clear accumulator; counter=0; go to MUL.
  - Inputs may change freely after this edge.
- MUL: one iteration per edge, WIDTH iterations total.
  - If multiplier bit[counter]=1, add (multiplicand << counter) to the OUTWIDTH-bit accumulator.
  - After iteration WIDTH-1, go to ADD.
- ADD: one edge.
  - fmadOut = accumulator + zext(addend) if sub=0, else accumulator − zext(addend), both modulo 2^OUTWIDTH.
  - Subtraction wraps (two's-complement result) when addend > product.
  - Set fmadDone=1; go to DONE.
- Latency: start sampled at edge 0; fmadDone=1 after edge WIDTH+1 (10 edges for WIDTH=8).
- DONE:
  - fmadOut and fmadDone held stable indefinitely.
  - start=1: fmadDone drops to 0 on that edge, operands latched, go to MUL (back-to-back operation, no IDLE cycle required).
- start while in MUL or ADD is ignored; latched operands unaffected.
- fmadOut changes only in ADD and on reset; it holds the previous result during a new computation.
- The product never overflows OUTWIDTH; only the add can overflow, and it wraps silently (no carry/borrow output).

Optional Feature:
- Macro: FMAD_SIGNED_EN.
- Defined:
  - All three operands are two's-complement signed.
  - Multiplier uses the magnitudes of the operands, then negates the product if the operand signs differ.
  - fmadAddIn is sign-extended.
  - fmadOut is a signed OUTWIDTH-bit result.
  - Latency is unchanged.
- Undefined: unsigned behaviour as described above.

Test Plan:
- Reset, then 200*100 + 50, sub=0 -> fmadDone after 10 edges; fmadOut=20050.
- 3*4, addend 20, sub=1 -> fmadOut=65528 (wrap of −8).
- 255*255 + 255, sub=0 -> fmadOut=65280; then 0*77, addend 1, sub=1 -> 65535.
- Assert reset during MUL (edge 4 of 7*9+1) -> fmadDone=0, fmadOut=0, state IDLE; next start with 7*9+1 -> 64.
- Back-to-back: start pulsed in DONE with 10*10−100 -> fmadDone falls on that edge; fmadOut=0 after 10 edges. Change inputs after the start edge -> result unaffected.
- Hold in DONE for 20 cycles with start=0 -> fmadOut and fmadDone unchanged; start pulsed during MUL is ignored.
